click_classifier: RTL



---
 rtl/ui_pkg.sv | 15 +
 rtl/click_classifier.sv | 99 +++++++++
 2 files changed

// File: rtl/ui_pkg.sv
// Shared UI-timing definitions: the click FSM state type and time-to-cycle conversion.
package ui_pkg;

  typedef enum logic [0:0] {
    IDLE,
    WAIT
  } click_state_t;

  // Number of clock cycles in a window of `us` microseconds at `freq_mhz` MHz.
  function automatic int unsigned cycles_from_us(input int unsigned freq_mhz,
                                                 input int unsigned us);
    return freq_mhz * us;
  endfunction

endpackage

// File: rtl/click_classifier.sv
// Groups debounced press strobes that arrive close together into single/double/.. click events.
// Emits one registered strobe with the press count per finished sequence.
module click_classifier
  import ui_pkg::*;
#(
  parameter int unsigned CLK_FREQ_MHZ    = 50,
  parameter int unsigned CLICK_WINDOW_US = 300000,
  parameter int unsigned MAX_CLICKS      = 3,
  localparam int unsigned CNT_W          = $clog2(MAX_CLICKS + 1)
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             key_pressed_stb_i,
  output logic             click_stb_o,
  output logic [CNT_W-1:0] click_cnt_o,
  output logic             busy_o
);

  localparam int unsigned WINDOW_CYCLES = cycles_from_us(CLK_FREQ_MHZ, CLICK_WINDOW_US);
  localparam int unsigned TIMER_W       = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;

  // The strobe is registered on the edge where the timer would reach WINDOW_CYCLES-1,
  // so the decision is taken while it still holds WINDOW_CYCLES-2.
  localparam logic [TIMER_W-1:0] TimerExpire = TIMER_W'(WINDOW_CYCLES - 2);
  localparam logic [TIMER_W-1:0] TimerMax    = TIMER_W'(WINDOW_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CntLast     = CNT_W'(MAX_CLICKS - 1);
  localparam logic [CNT_W-1:0]   CntMax      = CNT_W'(MAX_CLICKS);
  localparam logic [CNT_W-1:0]   CntOne      = CNT_W'(1);
  localparam logic [TIMER_W-1:0] TimerOne    = TIMER_W'(1);

  if (WINDOW_CYCLES < 2) begin : gen_window_chk
    $error("click_classifier: WINDOW_CYCLES must be >= 2");
  end
  if (MAX_CLICKS < 2) begin : gen_max_chk
    $error("click_classifier: MAX_CLICKS must be >= 2");
  end

  click_state_t       state_q;
  logic [CNT_W-1:0]   count_q;
  logic [TIMER_W-1:0] timer_q;
  logic               click_stb_q;
  logic [CNT_W-1:0]   click_cnt_q;
  logic               busy_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= IDLE;
      count_q     <= '0;
      timer_q     <= '0;
      click_stb_q <= 1'b0;
      click_cnt_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      click_stb_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (key_pressed_stb_i) begin
            state_q <= WAIT;
            count_q <= CntOne;
            timer_q <= '0;
            busy_q  <= 1'b1;
          end
        end
        WAIT: begin
          // A press always beats a coincident timeout.
          if (key_pressed_stb_i) begin
            timer_q <= '0;
            if (count_q == CntLast) begin
              click_stb_q <= 1'b1;
              click_cnt_q <= CntMax;
              state_q     <= IDLE;
              count_q     <= '0;
              busy_q      <= 1'b0;
            end else begin
              count_q <= count_q + CntOne;
            end
          end else if (timer_q == TimerExpire) begin
            click_stb_q <= 1'b1;
            click_cnt_q <= count_q;
            state_q     <= IDLE;
            count_q     <= '0;
            timer_q     <= '0;
            busy_q      <= 1'b0;
          end else if (timer_q != TimerMax) begin
            timer_q <= timer_q + TimerOne;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign click_stb_o = click_stb_q;
  assign click_cnt_o = click_cnt_q;
  assign busy_o      = busy_q;

endmodule
